freq_bcd_gate_counter: RTL and testbench
========================================

Name: freq_bcd_gate_counter

Overview:
- Counting/latching stage directly downstream of the frequency-meter timing controller.
- Counts rising edges of the measured signal while the gate (enb) is high. Captures the BCD result into an output latch on lock. Zeroes the running count on clr.
- Output feeds the 7-segment display driver; all logic runs in the single reference-clock domain.

Parameters:
DIGITS, 4, number of BCD digits (count range 0 to 10^DIGITS-1)
SYNC_STAGES, 2, synchroniser flops on sig_in (minimum 2)

Ports:
clk  input  1  reference clock; same clock as the timing controller
rst  input  1  asynchronous, active-high reset
sig_in  input  1  measured signal, asynchronous to clk
enb  input  1  count gate from timing controller, clk domain
lock  input  1  latch request from timing controller, clk domain
clr  input  1  counter clear from timing controller, clk domain
bcd_out  output  4*DIGITS  latched result, digit 0 = bits [3:0] (units)
ovf_out  output  1  latched overflow flag for the current bcd_out
valid  output  1  one-cycle pulse when bcd_out/ovf_out update

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset, asynchronous and immediate:
  - bcd_out = 0, ovf_out = 0, valid = 0.
  - Running BCD count = 0, sticky ovf = 0.
  - Synchroniser flops = 0, edge-history flop = 0, lock_d = 0.
- Reset mid-gate: count is lost. After release the block waits for the next clr/enb/lock sequence; no partial result is emitted.
- Input synchronisation: sig_in passes through SYNC_STAGES flops, then one history flop.
  - edge = sync_last & ~history.
  - A sig_in rise meeting setup before clk edge N gives edge=1 during the cycle after edge N+SYNC_STAGES-1. Increment lands at edge N+SYNC_STAGES (3 clocks with default 2 stages).
  - sig_in high or low time must be at least 2 clk periods; faster signals are out of spec and undercount.
- Counter update priority per clk edge:
  1. clr=1: count = 0 and sticky ovf = 0, regardless of enb/edge.
  2. Else enb=1 and edge=1: BCD increment.
  3. Else hold.
- BCD increment:
  - Digit k increments when all lower digits are 9. A digit at 9 rolls to 0 with carry.
  - Each digit is always in 0..9; binary values 10..15 never appear.
- Overflow: an increment from all-9s sets sticky ovf. Wrap or saturate behaviour is selected by the optional feature.
- Latch:
  - lock_d registers lock each cycle; a latch event occurs when lock=1 and lock_d=0.
  - Only one latch per lock assertion, however long lock stays high.
  - On a latch event: bcd_out = running count and ovf_out = sticky ovf, both taken as the pre-edge register values (an increment in the same cycle is not included). valid = 1 for that cycle only.
  - Without a latch event, bcd_out and ovf_out hold and valid = 0.
- Simultaneous events:
  - lock rise with clr=1: latch takes the pre-clear count; the clear also applies.
  - lock rise with enb=1: latch still occurs; the count keeps running.
- No handshake back to the timing controller; the block has no busy state.

Optional Feature:
- Macro: FREQ_CNT_SAT_EN.
- Defined: at all-9s the counter saturates. Further gated edges leave the count at all-9s and keep sticky ovf=1. bcd_out then shows the maximum (9999 for DIGITS=4) with ovf_out=1.
- Undefined: at all-9s the counter wraps to 0 and sets sticky ovf=1. Counting continues from 0 (9999 -> 0000, then 0001, ...). ovf_out=1 on the next latch marks the reading as modulo 10^DIGITS.

Test Plan:
- Reset: assert rst mid-count with enb=1 and 37 edges counted -> all outputs 0 immediately, before any clk edge. No valid pulse follows until a lock rise.
- Basic gate: clr pulse, enb high 8 clk, sig_in = clk/4 square wave, lock high 1 cycle -> 2 edges counted; bcd_out=0x0002, ovf_out=0, valid high exactly 1 cycle.
- BCD carry: preload via 1099 gated edges, then 1 more edge, lock -> bcd_out=0x1100; no digit ever exceeds 9 (check every cycle).
- Gate and clr priority: edges while enb=0 -> no change; clr=1 with enb=1 and edge -> count 0; lock held 5 cycles -> exactly one valid pulse.
- Overflow: 10001 gated edges, DIGITS=4, lock. Without FREQ_CNT_SAT_EN -> bcd_out=0x0001, ovf_out=1. With it -> bcd_out=0x9999, ovf_out=1. A following clr then lock -> bcd_out=0x0000, ovf_out=0.
- Same-cycle events: lock rise in the cycle an edge increments the count from 41 -> bcd_out=0x0041, and the next latch (no clr) shows 42 plus any later edges.

Source files
------------

// File: rtl/freq_bcd_gate_counter.sv
// Gated BCD edge counter with a lock-triggered output latch, clocked by the timing controller's clock.
// Build option FREQ_CNT_SAT_EN: the count saturates at all-9s instead of wrapping to zero.

module freq_bcd_digit (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clr,
   input  logic       i_inc,
   output logic [3:0] o_digit,
   output logic       o_is9
);
   logic [3:0] r_digit;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)      r_digit <= 4'd0;
      else if (i_clr) r_digit <= 4'd0;
      else if (i_inc) r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
   end

   assign o_digit = r_digit;
   assign o_is9   = (r_digit == 4'd9);
endmodule

module freq_bcd_gate_counter #(
   parameter int DIGITS      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_sig_in,
   input  logic                i_enb,
   input  logic                i_lock,
   input  logic                i_clr,
   output logic [4*DIGITS-1:0] o_bcd_out,
   output logic                o_ovf_out,
   output logic                o_valid
);
   logic [SYNC_STAGES-1:0]  r_sync;
   logic                    r_hist;
   logic                    r_lock_d;
   logic                    r_ovf;
   logic                    r_valid;
   logic                    r_ovf_out;
   logic [4*DIGITS-1:0]     r_bcd_out;
   logic [DIGITS-1:0][3:0]  w_digit;
   logic [DIGITS-1:0]       w_is9;
   logic [DIGITS-1:0]       w_carry;
   logic                    w_edge;
   logic                    w_all9;
   logic                    w_step;
   logic                    w_latch;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist;
   assign w_all9 = &w_is9;

`ifdef FREQ_CNT_SAT_EN
   // At all-9s the increment is suppressed so every digit holds at 9.
   assign w_step = i_enb & w_edge & ~w_all9;
`else
   assign w_step = i_enb & w_edge;
`endif

   // Digit k steps when every lower digit is 9; an all-9s step rolls every digit to 0.
   genvar k;
   generate
      for (k = 0; k < DIGITS; k++) begin : g_dig
         if (k == 0) begin : g_lsd
            assign w_carry[k] = w_step;
         end else begin : g_upper
            assign w_carry[k] = w_carry[k-1] & w_is9[k-1];
         end
         freq_bcd_digit u_dig (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_clr   (i_clr),
            .i_inc   (w_carry[k]),
            .o_digit (w_digit[k]),
            .o_is9   (w_is9[k])
         );
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                           r_ovf <= 1'b0;
      else if (i_clr)                      r_ovf <= 1'b0;
      else if (i_enb & w_edge & w_all9)    r_ovf <= 1'b1;
   end

   assign w_latch = i_lock & ~r_lock_d;

   // Latch samples the pre-edge count, so a same-cycle increment or clear is not seen.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lock_d  <= 1'b0;
         r_valid   <= 1'b0;
         r_bcd_out <= '0;
         r_ovf_out <= 1'b0;
      end else begin
         r_lock_d <= i_lock;
         r_valid  <= w_latch;
         if (w_latch) begin
            r_bcd_out <= w_digit;
            r_ovf_out <= r_ovf;
         end
      end
   end

   assign o_bcd_out = r_bcd_out;
   assign o_ovf_out = r_ovf_out;
   assign o_valid   = r_valid;
endmodule

// File: tb/tb_freq_bcd_gate_counter.sv
// Scoreboard bench for freq_bcd_gate_counter: an integer-count model queues expected latches,
// a negedge monitor pops them whenever valid is seen.

module tb_freq_bcd_gate_counter;
   localparam int DIGITS = 4;
   localparam int SYNC   = 2;
   localparam int MAXV   = 9999;
`ifdef FREQ_CNT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      logic [4*DIGITS-1:0] bcd;
      logic                ovf;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                sig = 1'b0;
   logic                enb = 1'b0;
   logic                lock = 1'b0;
   logic                clr = 1'b0;
   logic [4*DIGITS-1:0] bcd;
   logic                ovf;
   logic                vld;

   int   n_chk = 0;
   int   n_fail = 0;
   int   n_latch_exp = 0;
   int   n_valid_seen = 0;
   exp_t exp_q[$];
   exp_t e_mon;
   exp_t e_mdl;

   int   m_cnt = 0;
   logic m_ovf = 1'b0;
   logic m_lock_d = 1'b0;
   logic m_sig_d = 1'b0;
   logic m_due;
   logic rise_q[$];

   freq_bcd_gate_counter #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_sig_in  (sig),
      .i_enb     (enb),
      .i_lock    (lock),
      .i_clr     (clr),
      .o_bcd_out (bcd),
      .o_ovf_out (ovf),
      .o_valid   (vld)
   );

   always #5 clk = ~clk;

   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      int t;
      r = '0;
      t = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: a rise seen at clk edge N counts at edge N+SYNC when the gate is open.
   always @(posedge clk) begin
      if (rst) begin
         m_cnt = 0;
         m_ovf = 1'b0;
         m_lock_d = 1'b0;
         m_sig_d = 1'b0;
         rise_q.delete();
         exp_q.delete();
      end else begin
         if (lock && !m_lock_d) begin
            e_mdl.bcd = to_bcd(m_cnt);
            e_mdl.ovf = m_ovf;
            exp_q.push_back(e_mdl);
            n_latch_exp++;
         end
         m_lock_d = lock;
         rise_q.push_back(sig && !m_sig_d);
         m_sig_d = sig;
         m_due = (rise_q.size() > SYNC) ? rise_q.pop_front() : 1'b0;
         if (clr) begin
            m_cnt = 0;
            m_ovf = 1'b0;
         end else if (enb && m_due) begin
            if (m_cnt == MAXV) begin
               m_ovf = 1'b1;
               m_cnt = SAT ? MAXV : 0;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < DIGITS; d++) begin
            n_chk++;
            if (bcd[4*d +: 4] > 4'd9) begin
               n_fail++;
               $display("FAIL digit_range: digit %0d = %0d, required <= 9 at %0t", d, bcd[4*d +: 4], $time);
            end
         end
         if (vld) begin
            n_valid_seen++;
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_valid: valid=1 with no latch due, bcd_out=%0h at %0t", bcd, $time);
            end else begin
               e_mon = exp_q.pop_front();
               chk("bcd_out", 32'(bcd), 32'(e_mon.bcd));
               chk("ovf_out", 32'(ovf), 32'(e_mon.ovf));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic edges(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         int h;
         int l;
         h = rnd ? int'($urandom_range(2, 4)) : 2;
         l = rnd ? int'($urandom_range(2, 4)) : 2;
         sig = 1'b1;
         tick(h);
         sig = 1'b0;
         tick(l);
      end
   endtask

   task automatic pulse_lock(input int len);
      lock = 1'b1;
      tick(len);
      lock = 1'b0;
      tick(2);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int hold;
      #1;
      chk("reset_bcd", 32'(bcd), 32'h0);
      chk("reset_ovf", 32'(ovf), 32'h0);
      chk("reset_valid", 32'(vld), 32'h0);
      tick(3);
      rst = 1'b0;
      tick(2);

      // basic gate: clk/4 square wave for 8 gated cycles
      pulse_clr();
      enb = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sig = ((i % 4) < 2);
         tick(1);
      end
      enb = 1'b0;
      sig = 1'b0;
      tick(4);
      pulse_lock(1);

      // BCD carry through 1099 -> 1100
      pulse_clr();
      enb = 1'b1;
      edges(1099, 1'b1);
      tick(3);
      pulse_lock(1);
      edges(1, 1'b1);
      tick(3);
      pulse_lock(1);

      // gate closed: edges ignored
      enb = 1'b0;
      edges(5, 1'b1);
      tick(3);
      pulse_lock(1);

      // clr lands on the same edge as an increment
      enb = 1'b1;
      sig = 1'b1;
      tick(2);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      sig = 1'b0;
      tick(3);
      edges(3, 1'b1);
      tick(3);
      pulse_lock(5);

      // lock rise together with clr
      lock = 1'b1;
      clr = 1'b1;
      tick(1);
      lock = 1'b0;
      clr = 1'b0;
      tick(2);
      pulse_lock(1);

      // lock rise on the edge that steps 41 -> 42
      pulse_clr();
      edges(41, 1'b1);
      tick(3);
      sig = 1'b1;
      tick(2);
      lock = 1'b1;
      tick(1);
      lock = 1'b0;
      sig = 1'b0;
      tick(2);
      edges(4, 1'b1);
      tick(3);
      pulse_lock(1);

      // overflow past all-9s, then clear
      pulse_clr();
      edges(10001, 1'b0);
      tick(3);
      pulse_lock(1);
      pulse_clr();
      pulse_lock(1);

      // reset mid-gate after 37 edges
      pulse_clr();
      edges(37, 1'b1);
      tick(3);
      pulse_lock(1);
      edges(2, 1'b1);
      sig = 1'b1;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midrst_bcd", 32'(bcd), 32'h0);
      chk("midrst_ovf", 32'(ovf), 32'h0);
      chk("midrst_valid", 32'(vld), 32'h0);
      tick(2);
      sig = 1'b0;
      tick(1);
      rst = 1'b0;
      edges(3, 1'b1);
      tick(6);
      pulse_lock(1);

      // randomized gate/clr/lock/signal traffic
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         enb  = ($urandom_range(0, 9) < 8);
         clr  = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 7) == 0) lock = ~lock;
         hold++;
         if (hold >= 2 && $urandom_range(0, 1) == 1) begin
            sig = ~sig;
            hold = 0;
         end
         tick(1);
      end
      enb = 1'b0;
      clr = 1'b0;
      lock = 1'b0;
      sig = 1'b0;
      tick(4);
      pulse_lock(1);

      tick(5);
      chk("valid_count", 32'(n_valid_seen), 32'(n_latch_exp));
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
